// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the data-RAM arbiter.
// Widths default to a 4K-word, 32-bit data RAM; the wait counter covers thresholds 1..15.
package dmem_arb_pkg;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int WAIT_W     = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, aux and RAM signal bundle around the data-RAM arbiter.
// slave = arbiter side, master = processor/aux/RAM environment side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              aux_req;
  logic              aux_wren;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_rdata;

  logic              ram_wen;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    input  aux_req, aux_wren, aux_addr, aux_wdata,
    input  ram_dout,
    output cpu_rdata, cpu_stall,
    output aux_gnt, aux_rvalid, aux_rdata,
    output ram_wen, ram_addr, ram_din
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
    output aux_req, aux_wren, aux_addr, aux_wdata,
    output ram_dout,
    input  cpu_rdata, cpu_stall,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  ram_wen, ram_addr, ram_din
  );
endinterface

// File: rtl/dmem_arbiter_wait_counter.sv
// Counts consecutive cycles the aux request waits ungranted, saturating at MAX_WAIT.
// starve is registered-state only, so it never loops back through the grant logic.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic aux_req,
  input  logic aux_gnt,
  output logic starve
);
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!aux_req || aux_gnt) begin
      wait_cnt <= '0;
    end else if (wait_cnt != MAX_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign starve = (wait_cnt == MAX_CNT);
endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU owns the single RAM port by default, aux is served on CPU-idle cycles.
// Define DMEM_ARB_STARVE_EN to force an aux grant (stalling the CPU) after MAX_WAIT waits.
module dmem_arbiter
  import dmem_arb_pkg::*;
`ifdef DMEM_ARB_STARVE_EN
#(
  parameter int MAX_WAIT = 8
)
`endif
(
  input logic           clock,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  logic   starve;
  logic   aux_gnt;
  logic   rvalid_q;
  owner_t owner;

`ifdef DMEM_ARB_STARVE_EN
  arb_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .aux_req(bus.aux_req),
    .aux_gnt(aux_gnt),
    .starve (starve)
  );
  assign bus.cpu_stall = bus.cpu_req & aux_gnt;
`else
  assign starve        = 1'b0;
  assign bus.cpu_stall = 1'b0;
`endif

  assign aux_gnt     = bus.aux_req & (~bus.cpu_req | starve);
  assign owner       = aux_gnt ? OWN_AUX : OWN_CPU;
  assign bus.aux_gnt = aux_gnt;

  // The losing side's access simply does not reach the RAM this cycle.
  always_comb begin
    bus.ram_wen  = bus.cpu_req & bus.cpu_wren;
    bus.ram_addr = bus.cpu_addr;
    bus.ram_din  = bus.cpu_wdata;
    if (owner == OWN_AUX) begin
      bus.ram_wen  = bus.aux_wren;
      bus.ram_addr = bus.aux_addr;
      bus.ram_din  = bus.aux_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= aux_gnt & ~bus.aux_wren;
    end
  end

  assign bus.aux_rvalid = rvalid_q;
  assign bus.cpu_rdata  = bus.ram_dout;
  assign bus.aux_rdata  = bus.ram_dout;
endmodule
